// File: rtl/tx_dump_arbiter_pkg.sv
// Shared definitions for the TX dump arbiter: FSM states and frame marker bytes.
package tx_dump_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StTag,
    StAddr,
    StWait,
    StData,
    StTrl
  } arb_state_e;

  localparam logic [7:0] DMP_HDR = 8'hD5;
  localparam logic [7:0] DMP_TAG = 8'hC0;
  localparam logic [7:0] DMP_TRL = 8'h5D;

  // Tag byte announcing the chip select whose entries follow.
  function automatic logic [7:0] tag_byte(input logic [2:0] sel);
    return DMP_TAG | {5'b0, sel};
  endfunction

endpackage

// File: rtl/tx_dump_arbiter_if.sv
// Bundle of OUTBOX, dump-port and TX-serializer signals seen by the arbiter.
interface tx_dump_arbiter_if;

  logic       i_dump_req;
  logic       i_outbox_empty_n;
  logic [7:0] i_outbox_data;
  logic       o_pop_value;
  logic [2:0] o_dmp_chip_select;
  logic [4:0] o_dmp_fifo_pos;
  logic [7:0] i_dmp_data;
  logic       i_dmp_valid;
  logic       i_tx_busy;
  logic       o_tx_wr;
  logic [7:0] o_tx_data;
  logic       o_dumping;

  modport master (
    input  i_dump_req, i_outbox_empty_n, i_outbox_data, i_dmp_data, i_dmp_valid, i_tx_busy,
    output o_pop_value, o_dmp_chip_select, o_dmp_fifo_pos, o_tx_wr, o_tx_data, o_dumping
  );

  modport slave (
    output i_dump_req, i_outbox_empty_n, i_outbox_data, i_dmp_data, i_dmp_valid, i_tx_busy,
    input  o_pop_value, o_dmp_chip_select, o_dmp_fifo_pos, o_tx_wr, o_tx_data, o_dumping
  );

endinterface

// File: rtl/dump_addr_gen.sv
// Chip-select / FIFO-position walker for the memory dump sequencer.
module dump_addr_gen #(
  parameter int unsigned N_SEL = 4,
  parameter int unsigned DEPTH = 32
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       step,
  input  logic       clear,
  output logic [2:0] sel,
  output logic [4:0] pos,
  output logic       last_pos,
  output logic       last_sel
);

  localparam logic [2:0] LastSel = 3'(N_SEL - 1);
  localparam logic [4:0] LastPos = 5'(DEPTH - 1);

  logic [2:0] sel_q, sel_d;
  logic [4:0] pos_q, pos_d;

  // End-of-row / end-of-frame flags against the configured limits.
  always_comb begin
    last_pos = (pos_q == LastPos);
    last_sel = (sel_q == LastSel);
  end

  // Advance pos, rolling into the next sel; both return to 0 after the last entry.
  always_comb begin
    sel_d = sel_q;
    pos_d = pos_q;
    if (clear) begin
      sel_d = '0;
      pos_d = '0;
    end else if (step) begin
      if (!last_pos) begin
        pos_d = pos_q + 5'd1;
      end else begin
        pos_d = '0;
        sel_d = last_sel ? 3'd0 : sel_q + 3'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      sel_q <= '0;
      pos_q <= '0;
    end else begin
      sel_q <= sel_d;
      pos_q <= pos_d;
    end
  end

  assign sel = sel_q;
  assign pos = pos_q;

endmodule

// File: rtl/tx_dump_arbiter.sv
// Shares the UART-TX serializer between the CPU OUTBOX and the debug dump sequencer.
module tx_dump_arbiter
  import tx_dump_arbiter_pkg::*;
#(
  parameter int unsigned N_SEL = 4,
  parameter int unsigned DEPTH = 32
) (
  input logic               clk,
  input logic               i_rst,
  tx_dump_arbiter_if.master bus
);

  arb_state_e state_q, state_d;
  logic       pending_q, pending_d;
  logic       tx_wr_q, tx_wr_d;
  logic       pop_q, pop_d;
  logic       src_dump_q, src_dump_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [7:0] dmp_byte_q, dmp_byte_d;
  logic       dumping_q, dumping_d;

  logic       tx_free;
  logic       step, clear;
  logic [2:0] sel;
  logic [4:0] pos;
  logic       last_pos, last_sel;

  dump_addr_gen #(
    .N_SEL(N_SEL),
    .DEPTH(DEPTH)
  ) u_addr_gen (
    .clk     (clk),
    .i_rst   (i_rst),
    .step    (step),
    .clear   (clear),
    .sel     (sel),
    .pos     (pos),
    .last_pos(last_pos),
    .last_sel(last_sel)
  );

  // !tx_wr_q covers the cycle before the serializer raises busy.
  assign tx_free = !bus.i_tx_busy && !tx_wr_q;

  // Arbitration and dump sequencing.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    tx_wr_d    = 1'b0;
    pop_d      = 1'b0;
    src_dump_d = src_dump_q;
    tx_byte_d  = tx_byte_q;
    dmp_byte_d = dmp_byte_q;
    dumping_d  = dumping_q;
    step       = 1'b0;
    clear      = 1'b0;

    // Requests while a frame is in flight are dropped.
    if (bus.i_dump_req && (state_q == StIdle) && !dumping_q) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // Only reachable with dumping_q set during the trailer write cycle.
        if (dumping_q) begin
          dumping_d = 1'b0;
        end
        if (tx_free) begin
          // Dump outranks the OUTBOX so a saturated OUTBOX cannot starve it.
          if (pending_q) begin
            state_d   = StHdr;
            pending_d = 1'b0;
            dumping_d = 1'b1;
            clear     = 1'b1;
          end else if (bus.i_outbox_empty_n) begin
            pop_d      = 1'b1;
            tx_wr_d    = 1'b1;
            src_dump_d = 1'b0;
          end
        end
      end
      StHdr: begin
        if (tx_free) begin
          tx_wr_d    = 1'b1;
          src_dump_d = 1'b1;
          tx_byte_d  = DMP_HDR;
          state_d    = StTag;
        end
      end
      StTag: begin
        if (tx_free) begin
          tx_wr_d    = 1'b1;
          src_dump_d = 1'b1;
          tx_byte_d  = tag_byte(sel);
          state_d    = StAddr;
        end
      end
      StAddr: begin
        // Gives the dump port one cycle with the new address before valid is sampled.
        state_d = StWait;
      end
      StWait: begin
        if (bus.i_dmp_valid) begin
          dmp_byte_d = bus.i_dmp_data;
          state_d    = StData;
        end
      end
      StData: begin
        if (tx_free) begin
          tx_wr_d    = 1'b1;
          src_dump_d = 1'b1;
          tx_byte_d  = dmp_byte_q;
          step       = 1'b1;
          if (!last_pos) begin
            state_d = StAddr;
          end else if (!last_sel) begin
            state_d = StTag;
          end else begin
            state_d = StTrl;
          end
        end
      end
      StTrl: begin
        if (tx_free) begin
          tx_wr_d    = 1'b1;
          src_dump_d = 1'b1;
          tx_byte_d  = DMP_TRL;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any partial frame.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      pending_q  <= 1'b0;
      tx_wr_q    <= 1'b0;
      pop_q      <= 1'b0;
      src_dump_q <= 1'b0;
      tx_byte_q  <= '0;
      dmp_byte_q <= '0;
      dumping_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      tx_wr_q    <= tx_wr_d;
      pop_q      <= pop_d;
      src_dump_q <= src_dump_d;
      tx_byte_q  <= tx_byte_d;
      dmp_byte_q <= dmp_byte_d;
      dumping_q  <= dumping_d;
    end
  end

  // OUTBOX bytes pass straight through in the pop cycle; dump bytes come from tx_byte_q.
  always_comb begin
    bus.o_tx_data = 8'h00;
    if (tx_wr_q) begin
      bus.o_tx_data = src_dump_q ? tx_byte_q : bus.i_outbox_data;
    end
  end

  assign bus.o_tx_wr           = tx_wr_q;
  assign bus.o_pop_value       = pop_q;
  assign bus.o_dumping         = dumping_q;
  assign bus.o_dmp_chip_select = sel;
  assign bus.o_dmp_fifo_pos    = pos;

endmodule
